// File: rtl/seq_divider.sv
// seq_divider: multicycle restoring integer divider that produces one quotient
// bit per clock and uses a start/busy/done handshake.
// Optional feature macro: SEQ_DIVIDER_SIGNED_EN adds the sgn input for
// two's-complement operands. A build without the macro divides unsigned only.
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | waiting for start; results from the last op are held
// S_RUN  | iterating, one quotient bit per edge, busy=1
// S_DONE | single cycle with done=1; a new start is accepted here too

module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
`ifdef SEQ_DIVIDER_SIGNED_EN
  input  logic             sgn,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] prem_q;   // partial remainder
  logic [WIDTH-1:0] dvd_q;    // dividend shifts out at the top, quotient bits shift in at the bottom
  logic [WIDTH-1:0] dvs_q;
  logic             qneg_q;
  logic             rneg_q;
  logic             busy_q;
  logic             done_q;
  logic             dbz_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] rem_q;

  logic             sgn_w;
`ifdef SEQ_DIVIDER_SIGNED_EN
  assign sgn_w = sgn;
`else
  assign sgn_w = 1'b0;
`endif

  // Magnitudes of the incoming operands. They are used only when sgn_w is set.
  logic             dividend_neg;
  logic             divisor_neg;
  logic [WIDTH-1:0] dividend_mag;
  logic [WIDTH-1:0] divisor_mag;

  assign dividend_neg = sgn_w & dividend[WIDTH-1];
  assign divisor_neg  = sgn_w & divisor[WIDTH-1];
  assign dividend_mag = dividend_neg ? (~dividend + 1'b1) : dividend;
  assign divisor_mag  = divisor_neg  ? (~divisor  + 1'b1) : divisor;

  // One restoring step. The partial remainder is always below the divisor, so
  // the shifted value stays below 2*divisor. As a result, bit WIDTH of the
  // difference is a reliable borrow flag.
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   diff;
  logic             borrow;
  logic [WIDTH-1:0] prem_d;
  logic [WIDTH-1:0] dvd_d;
  logic [WIDTH-1:0] quo_res;
  logic [WIDTH-1:0] rem_res;

  assign rem_shift = {prem_q, dvd_q[WIDTH-1]};
  assign diff      = rem_shift - {1'b0, dvs_q};
  assign borrow    = diff[WIDTH];
  assign prem_d    = borrow ? rem_shift[WIDTH-1:0] : diff[WIDTH-1:0];
  assign dvd_d     = {dvd_q[WIDTH-2:0], ~borrow};

  // Sign fix-up at write-back. The most-negative / -1 case needs no special
  // path: its magnitude quotient of 2^(WIDTH-1) already reads as most-negative.
  assign quo_res = qneg_q ? (~dvd_d  + 1'b1) : dvd_d;
  assign rem_res = rneg_q ? (~prem_d + 1'b1) : prem_d;

  // Control FSM, datapath registers and registered handshake/result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      prem_q  <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          if (start) begin
            if (divisor == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              quo_q   <= '1;
              rem_q   <= dividend;
              dbz_q   <= 1'b1;
            end else begin
              state_q <= S_RUN;
              busy_q  <= 1'b1;
              cnt_q   <= '0;
              prem_q  <= '0;
              dvd_q   <= dividend_mag;
              dvs_q   <= divisor_mag;
              qneg_q  <= dividend_neg ^ divisor_neg;
              rneg_q  <= dividend_neg;
            end
          end
        end
        S_RUN: begin
          prem_q <= prem_d;
          dvd_q  <= dvd_d;
          cnt_q  <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_q <= S_DONE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            quo_q   <= quo_res;
            rem_q   <= rem_res;
            dbz_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: scoreboard bench for seq_divider. Each issued operation
// pushes its expected result and its expected done cycle. A monitor on the
// falling edge pops an entry on every done and checks busy and the held
// outputs on every other cycle.

module tb_seq_divider;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             sgn_r;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  seq_divider #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
`ifdef SEQ_DIVIDER_SIGNED_EN
    .sgn         (sgn_r),
`endif
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             z;
    int               due;
  } exp_t;

  exp_t sb_q[$];

  int vectors    = 0;
  int miscompares = 0;

  logic [WIDTH-1:0] last_q = '0;
  logic [WIDTH-1:0] last_r = '0;
  logic             last_z = 1'b0;
  int               run_lo = 1;
  int               run_hi = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain arithmetic on the operands' numeric values.
  function automatic void model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                input logic s, output logic [WIDTH-1:0] q,
                                output logic [WIDTH-1:0] r, output logic z);
    longint sa, sb, tq, tr;
    if (b == 0) begin
      q = '1;
      r = a;
      z = 1'b1;
      return;
    end
    z = 1'b0;
    if (s) begin
      sa = a[WIDTH-1] ? longint'(a) - (longint'(1) << WIDTH) : longint'(a);
      sb = b[WIDTH-1] ? longint'(b) - (longint'(1) << WIDTH) : longint'(b);
    end else begin
      sa = longint'(a);
      sb = longint'(b);
    end
    tq = sa / sb;    // truncates toward zero, remainder follows dividend sign
    tr = sa % sb;
    q = tq[WIDTH-1:0];
    r = tr[WIDTH-1:0];
  endfunction

  // Monitor: compares whenever the DUT presents a result, and checks holds otherwise.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy", {31'b0, busy}, {31'b0, (cyc >= run_lo && cyc <= run_hi)});
      if (done) begin
        if (sb_q.size() == 0) begin
          chk("spurious_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("done_cycle", cyc, e.due);
          chk("quotient", {{(32-WIDTH){1'b0}}, quotient}, {{(32-WIDTH){1'b0}}, e.q});
          chk("remainder", {{(32-WIDTH){1'b0}}, remainder}, {{(32-WIDTH){1'b0}}, e.r});
          chk("div_by_zero", {31'b0, div_by_zero}, {31'b0, e.z});
          last_q = e.q;
          last_r = e.r;
          last_z = e.z;
        end
      end else begin
        chk("hold_q", {{(32-WIDTH){1'b0}}, quotient}, {{(32-WIDTH){1'b0}}, last_q});
        chk("hold_r", {{(32-WIDTH){1'b0}}, remainder}, {{(32-WIDTH){1'b0}}, last_r});
        chk("hold_z", {31'b0, div_by_zero}, {31'b0, last_z});
      end
    end
  end

  // Call this task only at posedge+1. It waits for the DUT to accept a start,
  // then it records the expected response.
  task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s);
    exp_t e;
    int   n;
    n = 0;
    while (busy && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy) begin
      chk("issue_timeout", 32'd1, 32'd0);
      return;
    end
    dividend = a;
    divisor  = b;
    sgn_r    = s;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    model(a, b, s, e.q, e.r, e.z);
    // A zero divisor goes straight to DONE on the start edge. Any other
    // divisor runs WIDTH RUN cycles first.
    e.due = (b == 0) ? cyc : cyc + WIDTH;
    sb_q.push_back(e);
    if (b != 0) begin
      run_lo = cyc;
      run_hi = cyc + WIDTH - 1;
    end
    dividend = WIDTH'($urandom);
    divisor  = WIDTH'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int n;
    logic [WIDTH-1:0] a, b;
    logic s;
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    sgn_r    = 1'b0;
    #2;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_q", {{(32-WIDTH){1'b0}}, quotient}, 32'd0);
    chk("rst_r", {{(32-WIDTH){1'b0}}, remainder}, 32'd0);
    chk("rst_z", {31'b0, div_by_zero}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    issue(8'd100, 8'd7, 1'b0);
    issue(8'd255, 8'd1, 1'b0);
    issue(8'd5, 8'd9, 1'b0);          // starts in the DONE cycle of 255/1
    idle(WIDTH + 3);
    issue(8'd37, 8'd0, 1'b0);
    issue(8'd200, 8'd10, 1'b0);
    idle(WIDTH + 2);

    // Reset during the 4th RUN cycle of 200/3.
    issue(8'd200, 8'd3, 1'b0);
    idle(3);
    #2;
    rst_n = 1'b0;
    sb_q.delete();
    last_q = '0;
    last_r = '0;
    last_z = 1'b0;
    run_lo = 1;
    run_hi = 0;
    #1;
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    chk("midrst_done", {31'b0, done}, 32'd0);
    chk("midrst_q", {{(32-WIDTH){1'b0}}, quotient}, 32'd0);
    chk("midrst_r", {{(32-WIDTH){1'b0}}, remainder}, 32'd0);
    chk("midrst_z", {31'b0, div_by_zero}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);
    issue(8'd9, 8'd4, 1'b0);
    idle(WIDTH + 2);

    // A start pulse and operand changes arrive while busy. The DUT must ignore them.
    issue(8'd150, 8'd11, 1'b0);
    idle(2);
    start    = 1'b1;
    dividend = 8'd3;
    divisor  = 8'd1;
    @(posedge clk); #1;
    start    = 1'b0;
    divisor  = 8'd0;
    idle(WIDTH + 2);

`ifdef SEQ_DIVIDER_SIGNED_EN
    issue(8'hF9, 8'd2, 1'b1);         // -7 / 2
    issue(8'd7, 8'hFE, 1'b1);         // 7 / -2
    issue(8'h80, 8'hFF, 1'b1);        // -128 / -1
    issue(8'h80, 8'd0, 1'b1);         // -128 / 0
    idle(WIDTH + 2);
`endif

    for (int i = 0; i < 60; i++) begin
      a = WIDTH'($urandom);
      case ($urandom_range(0, 7))
        0:       b = '0;
        1:       b = 8'd1;
        2:       b = WIDTH'($urandom_range(2, 15));
        default: b = WIDTH'($urandom);
      endcase
      s = 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
      s = 1'($urandom);
`endif
      idle($urandom_range(0, 2));
      issue(a, b, s);
      if ($urandom_range(0, 3) == 0 && busy) begin
        start = 1'b1;
        dividend = WIDTH'($urandom);
        divisor  = WIDTH'($urandom);
        @(posedge clk); #1;
        start = 1'b0;
      end
    end

    n = 0;
    while (sb_q.size() > 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_empty", sb_q.size(), 32'd0);
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
